// File: rtl/spi_arb.sv
// Round-robin arbiter that shares one spi_if between NREQ requesters and loads the winner's config word first.
// Optional owner-inactivity watchdog is built when SPI_ARB_WDOG_EN is defined.
module spi_arb #(
   parameter int unsigned NREQ        = 2,
   parameter int unsigned IDLE_CYC    = 4,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   output logic [NREQ-1:0]      gnt,
   input  logic [NREQ*11-1:0]   req_cfg,
   input  logic [NREQ*11-1:0]   req_din,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ-1:0]      req_rd,
   input  logic [NREQ-1:0]      req_cmd,
   output logic [NREQ-1:0]      req_ack,
   output logic [8:0]           req_dout,
   output logic [10:0]          spi_din,
   output logic                 spi_wr,
   output logic                 spi_rd,
   output logic                 spi_cmd,
   input  logic                 spi_ack,
   input  logic [8:0]           spi_dout,
   input  logic                 spi_ss,
   output logic                 wdog_err
);

   localparam int unsigned DW = 11;
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(IDLE_CYC + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CFG     = 3'd1;
   localparam logic [2:0] S_CFG_ACK = 3'd2;
   localparam logic [2:0] S_OWN     = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;

   logic [2:0]      state, state_d;
   logic [IW-1:0]   owner, owner_d;
   logic [IW-1:0]   last, last_d;
   logic [IW-1:0]   pick;
   logic            pick_vld;
   logic [CW-1:0]   dcnt, dcnt_d;
   logic            pend, pend_d;
   logic            own_stb;
   logic [NREQ-1:0] elig;
   logic [DW-1:0]   cfg_a [NREQ];
   logic [DW-1:0]   din_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign cfg_a[i] = req_cfg[DW*i +: DW];
      assign din_a[i] = req_din[DW*i +: DW];
   end

   assign own_stb  = req_wr[owner] | req_rd[owner] | req_cmd[owner];
   assign req_dout = spi_dout;

`ifdef SPI_ARB_WDOG_EN
   localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

   logic [WW-1:0]   wcnt, wcnt_d;
   logic [NREQ-1:0] blk, blk_d;
   logic            revoke;

   // A revoked requester stays blocked until it drops its request once.
   assign elig = req & ~blk;
`else
   assign elig = req;
`endif

   // Round-robin pick: first eligible requester after the last winner, with wrap.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         if (!pick_vld && elig[IW'((32'(last) + k) % NREQ)]) begin
            pick_vld = 1'b1;
            pick     = IW'((32'(last) + k) % NREQ);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      owner_d = owner;
      last_d  = last;
      dcnt_d  = '0;
      pend_d  = 1'b0;
`ifdef SPI_ARB_WDOG_EN
      wcnt_d  = '0;
      blk_d   = blk & req;
      revoke  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               owner_d = pick;
               last_d  = pick;
               state_d = S_CFG;
            end
         end
         S_CFG: state_d = S_CFG_ACK;
         S_CFG_ACK: begin
            if (spi_ack) state_d = req[owner] ? S_OWN : S_DRAIN;
         end
         S_OWN: begin
            pend_d = own_stb;
            if (!req[owner]) begin
               state_d = S_DRAIN;
            end
`ifdef SPI_ARB_WDOG_EN
            else if (own_stb) begin
               wcnt_d = '0;
            end else if (wcnt == WW'(WDOG_CYCLES - 1)) begin
               revoke       = 1'b1;
               blk_d[owner] = 1'b1;
               state_d      = S_DRAIN;
            end else begin
               wcnt_d = wcnt + WW'(1);
            end
`endif
         end
         S_DRAIN: begin
            // Link must stay quiet for IDLE_CYC consecutive cycles before regrant.
            if (spi_ss) begin
               if (dcnt == CW'(IDLE_CYC - 1)) state_d = S_IDLE;
               else                           dcnt_d  = dcnt + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode; owner strobes pass straight through while it holds the link.
   always_comb begin
      gnt     = '0;
      req_ack = '0;
      spi_wr  = 1'b0;
      spi_rd  = 1'b0;
      spi_cmd = 1'b0;
      spi_din = '0;
      case (state)
         S_CFG: begin
            spi_cmd = 1'b1;
            spi_din = cfg_a[owner];
         end
         S_OWN: begin
            gnt[owner]     = req[owner];
            spi_wr         = req_wr[owner];
            spi_rd         = req_rd[owner];
            spi_cmd        = req_cmd[owner];
            spi_din        = din_a[owner];
            req_ack[owner] = spi_ack;
         end
         S_DRAIN: req_ack[owner] = spi_ack & pend;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         owner <= '0;
         last  <= IW'(NREQ - 1);
         dcnt  <= '0;
         pend  <= 1'b0;
      end else begin
         state <= state_d;
         owner <= owner_d;
         last  <= last_d;
         dcnt  <= dcnt_d;
         pend  <= pend_d;
      end
   end

`ifdef SPI_ARB_WDOG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt     <= '0;
         blk      <= '0;
         wdog_err <= 1'b0;
      end else begin
         wcnt     <= wcnt_d;
         blk      <= blk_d;
         wdog_err <= revoke;
      end
   end
`else
   // Watchdog compiled out: the limit has no effect and the error output stays low.
   assign wdog_err = 1'b0 & (WDOG_CYCLES != 0);
`endif

endmodule
